// File: rtl/pin_pulser.sv
// Turns single-cycle requests into fixed-width pulses on a pin, queueing
// requests that arrive mid-pulse and replaying them with a guaranteed gap.
module pin_pulser #(
  parameter bit          C_ACTIVE      = 1'b1,
  parameter int unsigned C_CLK_FREQ    = 100000000,
  parameter int unsigned C_ON_MS       = 100,
  parameter int unsigned C_OFF_MS      = 100,
  parameter int unsigned C_MAX_PENDING = 15
) (
  input  logic                                  CLK,
  input  logic                                  RESETN,
  input  logic                                  TRIG,
  input  logic                                  CLEAR,
  output logic                                  PIN,
  output logic                                  BUSY,
  output logic [$clog2(C_MAX_PENDING+1)-1:0]    PENDING,
  output logic                                  OVERFLOW
);

  localparam int unsigned ON_CYCLES  = C_CLK_FREQ / 1000 * C_ON_MS;
  localparam int unsigned OFF_CYCLES = C_CLK_FREQ / 1000 * C_OFF_MS;
  localparam int unsigned MAX_CYCLES = (ON_CYCLES > OFF_CYCLES) ? ON_CYCLES : OFF_CYCLES;
  localparam int unsigned TW         = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;
  localparam int unsigned PW         = $clog2(C_MAX_PENDING + 1);

  localparam logic [TW-1:0] ON_LOAD  = TW'(ON_CYCLES - 1);
  localparam logic [TW-1:0] OFF_LOAD = TW'(OFF_CYCLES - 1);
  localparam logic [PW-1:0] PEND_MAX = PW'(C_MAX_PENDING);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ON,
    ST_GAP
  } state_t;

  state_t        state;
  logic [TW-1:0] timer;
  logic          have_pending;
  logic          deq;
  logic          full;

  assign have_pending = (PENDING != '0);
  assign full         = (PENDING == PEND_MAX);

  // A pulse starts from IDLE, or straight out of an expiring gap so the
  // period stays exactly ON+OFF when requests are queued back to back.
  always_comb begin
    deq = 1'b0;
    if (have_pending) begin
      if (state == ST_IDLE) begin
        deq = 1'b1;
      end else if (state == ST_GAP && timer == '0) begin
        deq = 1'b1;
      end
    end
  end

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      state    <= ST_IDLE;
      timer    <= '0;
      PENDING  <= '0;
      OVERFLOW <= 1'b0;
      PIN      <= ~C_ACTIVE;
    end else if (CLEAR) begin
      state    <= ST_IDLE;
      timer    <= '0;
      PENDING  <= '0;
      OVERFLOW <= 1'b0;
      PIN      <= ~C_ACTIVE;
    end else begin
      OVERFLOW <= TRIG && !deq && full;

      if (TRIG && !deq && !full) begin
        PENDING <= PENDING + PW'(1);
      end else if (!TRIG && deq) begin
        PENDING <= PENDING - PW'(1);
      end

      case (state)
        ST_IDLE: begin
          if (have_pending) begin
            state <= ST_ON;
            timer <= ON_LOAD;
            PIN   <= C_ACTIVE;
          end else begin
            PIN   <= ~C_ACTIVE;
          end
        end
        ST_ON: begin
          if (timer == '0) begin
            state <= ST_GAP;
            timer <= OFF_LOAD;
            PIN   <= ~C_ACTIVE;
          end else begin
            timer <= timer - TW'(1);
            PIN   <= C_ACTIVE;
          end
        end
        ST_GAP: begin
          if (timer == '0) begin
            if (have_pending) begin
              state <= ST_ON;
              timer <= ON_LOAD;
              PIN   <= C_ACTIVE;
            end else begin
              state <= ST_IDLE;
              PIN   <= ~C_ACTIVE;
            end
          end else begin
            timer <= timer - TW'(1);
            PIN   <= ~C_ACTIVE;
          end
        end
        default: begin
          state <= ST_IDLE;
          timer <= '0;
          PIN   <= ~C_ACTIVE;
        end
      endcase
    end
  end

  assign BUSY = (state != ST_IDLE) || have_pending;

endmodule

// File: tb/tb_pin_pulser.sv
// Bench for pin_pulser: phase-based reference model compared every cycle
// against an active-high and an active-low instance, plus pinned literals.
module tb_pin_pulser;

  localparam int ON   = 3;
  localparam int OFF  = 2;
  localparam int PER  = ON + OFF;
  localparam int MAXP = 3;

  logic       CLK = 1'b0;
  logic       RESETN = 1'b0;
  logic       TRIG = 1'b0;
  logic       CLEAR = 1'b0;
  logic       pin_h, busy_h, ovf_h;
  logic       pin_l, busy_l, ovf_l;
  logic [1:0] pend_h, pend_l;

  int total = 0;
  int bad   = 0;
  int ec    = 0;

  pin_pulser #(
    .C_ACTIVE(1'b1), .C_CLK_FREQ(1000), .C_ON_MS(ON), .C_OFF_MS(OFF), .C_MAX_PENDING(MAXP)
  ) dut_h (
    .CLK(CLK), .RESETN(RESETN), .TRIG(TRIG), .CLEAR(CLEAR),
    .PIN(pin_h), .BUSY(busy_h), .PENDING(pend_h), .OVERFLOW(ovf_h)
  );

  pin_pulser #(
    .C_ACTIVE(1'b0), .C_CLK_FREQ(1000), .C_ON_MS(ON), .C_OFF_MS(OFF), .C_MAX_PENDING(MAXP)
  ) dut_l (
    .CLK(CLK), .RESETN(RESETN), .TRIG(TRIG), .CLEAR(CLEAR),
    .PIN(pin_l), .BUSY(busy_l), .PENDING(pend_l), .OVERFLOW(ovf_l)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) ec <= ec + 1;

  // Model: a running pulse is tracked by its age m_t (0..PER-1) since it
  // started; the pin is active for the first ON cycles of that age.
  bit   m_act;
  int   m_t;
  int   m_pend;
  bit   m_ovf;
  logic m_start, m_end;

  assign m_start = (m_pend != 0) && (!m_act || m_t == PER - 1);
  assign m_end   = m_act && (m_t == PER - 1) && (m_pend == 0);

  always @(posedge CLK or negedge RESETN) begin
    if (!RESETN || CLEAR) begin
      m_act  <= 1'b0;
      m_t    <= 0;
      m_pend <= 0;
      m_ovf  <= 1'b0;
    end else begin
      m_ovf <= TRIG && !m_start && (m_pend == MAXP);
      if (TRIG && !m_start) m_pend <= (m_pend == MAXP) ? m_pend : m_pend + 1;
      else if (!TRIG && m_start) m_pend <= m_pend - 1;
      if (m_start) begin
        m_act <= 1'b1;
        m_t   <= 0;
      end else if (m_end) begin
        m_act <= 1'b0;
      end else if (m_act) begin
        m_t <= m_t + 1;
      end
    end
  end

  typedef struct {
    int    e;
    int    sig;
    int    val;
  } lit_t;
  lit_t lits[$];

  function automatic void add(input int e, input int sig, input int val);
    lit_t l;
    l.e = e; l.sig = sig; l.val = val;
    lits.push_back(l);
  endfunction

  task automatic chk(input string nm, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s edge=%0d got=%0d exp=%0d", nm, ec, got, exp);
    end
  endtask

  function automatic int sig_val(input int sig);
    case (sig)
      0: return int'(pin_h);
      1: return int'(busy_h);
      2: return int'(pend_h);
      3: return int'(ovf_h);
      default: return int'(pin_l);
    endcase
  endfunction

  initial begin
    int exp_pin;
    int exp_busy;
    forever begin
      @(negedge CLK);
      exp_pin  = (m_act && m_t < ON) ? 1 : 0;
      exp_busy = (m_act || m_pend != 0) ? 1 : 0;
      chk("pin_h",  int'(pin_h),  exp_pin);
      chk("pin_l",  int'(pin_l),  1 - exp_pin);
      chk("busy_h", int'(busy_h), exp_busy);
      chk("busy_l", int'(busy_l), exp_busy);
      chk("pend_h", int'(pend_h), m_pend);
      chk("pend_l", int'(pend_l), m_pend);
      chk("ovf_h",  int'(ovf_h),  int'(m_ovf));
      chk("ovf_l",  int'(ovf_l),  int'(m_ovf));
      foreach (lits[i]) begin
        if (lits[i].e == ec) chk($sformatf("lit_sig%0d", lits[i].sig), sig_val(lits[i].sig), lits[i].val);
      end
    end
  end

  task automatic at_edge(input int k, input logic t, input logic c);
    while (ec < k - 1) begin
      @(posedge CLK); #1;
    end
    TRIG = t; CLEAR = c;
    @(posedge CLK); #1;
    TRIG = 1'b0; CLEAR = 1'b0;
  endtask

  task automatic after_edge(input int k);
    while (ec < k) begin
      @(posedge CLK); #1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog edge=%0d got=timeout exp=finish", ec);
    $fatal(1);
  end

  initial begin
    // 0 PIN, 1 BUSY, 2 PENDING, 3 OVERFLOW, 4 PIN of active-low instance
    add(2, 0, 0);  add(2, 1, 0);  add(2, 2, 0);  add(2, 3, 0);  add(2, 4, 1);
    add(50, 0, 0); add(50, 1, 0); add(50, 2, 0);
    add(70, 2, 1); add(70, 0, 0); add(70, 1, 1); add(70, 4, 1);
    add(71, 0, 1); add(71, 2, 0); add(71, 4, 0); add(73, 0, 1); add(73, 4, 0);
    add(74, 0, 0); add(74, 1, 1); add(74, 4, 1); add(75, 1, 1); add(76, 1, 0);
    add(111, 0, 1); add(114, 0, 0); add(116, 0, 1); add(119, 0, 0);
    add(121, 0, 1); add(123, 0, 1); add(124, 0, 0); add(125, 1, 1); add(126, 1, 0);
    add(153, 2, 3); add(154, 3, 1); add(154, 2, 3); add(155, 3, 0);
    add(166, 0, 1); add(166, 2, 0); add(169, 0, 0); add(171, 1, 0);
    add(191, 0, 1); add(192, 0, 0); add(192, 2, 0); add(192, 1, 0); add(193, 1, 0);
    add(200, 2, 1); add(201, 0, 1);
    add(222, 0, 0); add(222, 4, 1); add(222, 2, 0); add(222, 1, 0);

    after_edge(3);
    RESETN = 1'b1;

    at_edge(70, 1'b1, 1'b0);

    at_edge(110, 1'b1, 1'b0);
    at_edge(111, 1'b1, 1'b0);
    at_edge(112, 1'b1, 1'b0);

    for (int k = 150; k <= 154; k++) at_edge(k, 1'b1, 1'b0);

    at_edge(190, 1'b1, 1'b0);
    at_edge(191, 1'b1, 1'b0);
    at_edge(192, 1'b1, 1'b1);
    at_edge(200, 1'b1, 1'b0);

    at_edge(220, 1'b1, 1'b0);
    at_edge(221, 1'b1, 1'b0);
    after_edge(222);
    #1 RESETN = 1'b0;
    after_edge(225);
    RESETN = 1'b1;

    for (int i = 0; i < 3000; i++) begin
      int prob;
      prob = ((i / 400) % 2 == 1) ? 60 : 12;
      @(posedge CLK); #1;
      TRIG  = ($urandom_range(0, 99) < prob);
      CLEAR = ($urandom_range(0, 79) == 0);
      if ($urandom_range(0, 249) == 0) begin
        #1 RESETN = 1'b0;
        @(posedge CLK); #1;
        RESETN = 1'b1;
      end
    end
    @(posedge CLK); #1;
    TRIG = 1'b0; CLEAR = 1'b0;
    repeat (20) @(posedge CLK);
    @(negedge CLK); #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
